// File: rtl/vic_pkg.sv
// Shared types and helpers for the vectored interrupt controller (vic_wb / vic_arb).
// Rotating priority is built when VIC_ROUND_ROBIN_EN is defined; the default build uses fixed priority.
package vic_pkg;

    localparam int VEC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LATCH    = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_REL = 2'd3
    } vic_state_e;

    // Interrupt vectors are word-aligned on the CPU bus, so the two low bits never reach it.
    function automatic logic [VEC_W-1:0] vic_align(input logic [VEC_W-1:0] vec);
        return {vec[VEC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/vic_arb.sv
// Combinational request picker returning the winning index and a valid flag.
// VIC_ROUND_ROBIN_EN: the search starts at 'start'; otherwise bit 0 always has the highest priority.
module vic_arb
    import vic_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          valid
);

`ifdef VIC_ROUND_ROBIN_EN
    always_comb begin
        int k;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        // Walk the ring once from 'start'; the first requester met wins.
        for (int i = 0; i < N; i++) begin
            k = int'(start) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = IW'(k);
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/vic_wb.sv
// Vectored interrupt controller driving the CPU virq/ivec/istb/iack port.
// Define VIC_ROUND_ROBIN_EN for rotating priority; the default build is fixed priority, bit 0 highest.
//
// Handshake: the CPU raises istb and holds it until it has seen iack. The controller latches
// the winner, presents ivec, raises iack after IACK_DLY cycles and holds it until istb falls.
// Dropping istb before iack aborts the cycle without acknowledging any source.
module vic_wb
    import vic_pkg::*;
#(
    parameter int N        = 4,
    parameter int IACK_DLY = 1
) (
    input  logic               clk_p,
    input  logic               rst_n,
    input  logic               init,
    input  logic [N-1:0]       irq,
    input  logic [N*VEC_W-1:0] vec,
    output logic               virq,
    output logic [VEC_W-1:0]   ivec,
    input  logic               istb,
    output logic               iack,
    output logic [N-1:0]       irq_ack,
    output vic_state_e         dbg_state
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    // ACK fires when the counter reads 0, so load one less than the requested delay.
    localparam logic [1:0] DLY_INIT = (IACK_DLY > 0) ? 2'(IACK_DLY - 1) : 2'd0;

    vic_state_e      state;
    logic            istb_q;
    logic [1:0]      dly_cnt;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [IW-1:0]   arb_start;
    logic [VEC_W-1:0] arb_vec;
    logic [N-1:0]    arb_mask;
    logic [N-1:0]    win_mask;

`ifdef VIC_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;
    assign arb_start = rr_ptr;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] cur);
        return (cur == IW'(N - 1)) ? '0 : cur + 1'b1;
    endfunction
`else
    assign arb_start = '0;
`endif

    vic_arb #(.N(N)) u_arb (
        .req   (irq),
        .start (arb_start),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        arb_vec  = '0;
        arb_mask = '0;
        win_mask = '0;
        for (int k = 0; k < N; k++) begin
            if (arb_idx == IW'(k)) begin
                arb_vec = vic_align(vec[k*VEC_W +: VEC_W]);
            end
            arb_mask[k] = arb_valid && (arb_idx == IW'(k));
            win_mask[k] = win_valid && (win_idx == IW'(k));
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk_p) begin
        if (!rst_n || init) begin
            state     <= ST_IDLE;
            istb_q    <= 1'b0;
            virq      <= 1'b0;
            ivec      <= '0;
            iack      <= 1'b0;
            irq_ack   <= '0;
            dly_cnt   <= '0;
            win_idx   <= '0;
            win_valid <= 1'b0;
`ifdef VIC_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            istb_q  <= istb;
            irq_ack <= '0;
            case (state)
                ST_IDLE: begin
                    virq <= |irq;
                    iack <= 1'b0;
                    ivec <= '0;
                    if (istb && !istb_q) begin
                        virq  <= 1'b0;
                        state <= ST_LATCH;
                    end
                end

                ST_LATCH: begin
                    virq <= 1'b0;
                    if (!istb) begin
                        ivec      <= '0;
                        win_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        win_idx   <= arb_idx;
                        win_valid <= arb_valid;
                        ivec      <= arb_valid ? arb_vec : '0;
                        dly_cnt   <= DLY_INIT;
                        if (IACK_DLY == 0) begin
                            // Zero delay: vector and acknowledge leave together.
                            iack    <= 1'b1;
                            irq_ack <= arb_mask;
`ifdef VIC_ROUND_ROBIN_EN
                            if (arb_valid) begin
                                rr_ptr <= next_ptr(arb_idx);
                            end
`endif
                            state   <= ST_WAIT_REL;
                        end else begin
                            state <= ST_ACK;
                        end
                    end
                end

                ST_ACK: begin
                    virq <= 1'b0;
                    if (!istb) begin
                        ivec      <= '0;
                        win_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (dly_cnt == 2'd0) begin
                        iack    <= 1'b1;
                        irq_ack <= win_mask;
`ifdef VIC_ROUND_ROBIN_EN
                        if (win_valid) begin
                            rr_ptr <= next_ptr(win_idx);
                        end
`endif
                        state   <= ST_WAIT_REL;
                    end else begin
                        dly_cnt <= dly_cnt - 2'd1;
                    end
                end

                ST_WAIT_REL: begin
                    virq <= 1'b0;
                    if (!istb) begin
                        iack      <= 1'b0;
                        ivec      <= '0;
                        win_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    virq  <= 1'b0;
                    iack  <= 1'b0;
                    ivec  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vic_wb.sv
// Bench for vic_wb: two instances (IACK_DLY=1 and 3) share stimulus and are checked against
// a transaction-level model of winner selection, vector alignment and handshake timing.
module tb_vic_wb;
    import vic_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    logic           rst_n, init, istb;
    logic [N-1:0]   irq;
    logic [N*W-1:0] vec;

    logic           virq_a, iack_a, virq_b, iack_b;
    logic [W-1:0]   ivec_a, ivec_b;
    logic [N-1:0]   irq_ack_a, irq_ack_b;
    vic_state_e     st_a, st_b;

    vic_wb #(.N(N), .IACK_DLY(1)) dut_a (
        .clk_p(clk_p), .rst_n(rst_n), .init(init), .irq(irq), .vec(vec),
        .virq(virq_a), .ivec(ivec_a), .istb(istb), .iack(iack_a),
        .irq_ack(irq_ack_a), .dbg_state(st_a)
    );

    vic_wb #(.N(N), .IACK_DLY(3)) dut_b (
        .clk_p(clk_p), .rst_n(rst_n), .init(init), .irq(irq), .vec(vec),
        .virq(virq_b), .ivec(ivec_b), .istb(istb), .iack(iack_b),
        .irq_ack(irq_ack_b), .dbg_state(st_b)
    );

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] vec_m [N];
    int           ptr_m = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic set_vecs();
        for (int k = 0; k < N; k++) vec[k*W +: W] = vec_m[k];
    endtask

    function automatic int start_idx();
`ifdef VIC_ROUND_ROBIN_EN
        return ptr_m;
`else
        return 0;
`endif
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) if (r[(start + i) % N]) return (start + i) % N;
        return -1;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            irq = N'($urandom_range(0, (1 << N) - 1));
            tick();
            chk("virq_a_idle", virq_a, |irq);
            chk("virq_b_idle", virq_b, |irq);
        end
    endtask

    // Full acknowledge cycle; kill=1 pulses init during WAIT_REL instead of releasing istb.
    task automatic run_ack(input bit kill, input bit keep_irq, input bit have_want,
                           input logic [W-1:0] want_vec, input logic [N-1:0] want_mask);
        int w;
        int extra;
        logic [W-1:0] ev;
        logic [N-1:0] em;
        w  = pick(irq, start_idx());
        ev = '0;
        em = '0;
        if (w >= 0) begin
            ev    = vec_m[w] & 16'hfffc;
            em[w] = 1'b1;
        end
        if (have_want) begin
            ev = want_vec;
            em = want_mask;
        end
        exp_q.push_back(ev);
        extra = $urandom_range(0, 2);
        istb  = 1'b1;
        tick();
        chk("virq_a_latch", virq_a, 0);
        chk("virq_b_latch", virq_b, 0);
        chk("iack_a_early", iack_a, 0);
        tick();
        chk("ivec_a_t1", ivec_a, ev);
        chk("ivec_b_t1", ivec_b, ev);
        chk("iack_a_t1", iack_a, 0);
        chk("iack_b_t1", iack_b, 0);
        chk("irq_ack_a_t1", irq_ack_a, 0);
        if (!keep_irq) begin
            irq = N'($urandom_range(0, (1 << N) - 1));
            for (int k = 0; k < N; k++) vec_m[k] = 16'($urandom);
            set_vecs();
        end
        for (int c = 2; c <= 4 + extra; c++) begin
            tick();
            chk("iack_a", iack_a, (c >= 2));
            chk("irq_ack_a", irq_ack_a, (c == 2) ? em : '0);
            chk("iack_b", iack_b, (c >= 4));
            chk("irq_ack_b", irq_ack_b, (c == 4) ? em : '0);
            chk("ivec_a_hold", ivec_a, ev);
            chk("ivec_b_hold", ivec_b, ev);
            chk("virq_a_busy", virq_a, 0);
            if (c == 4) chk("sb_ivec_b", ivec_b, exp_q.pop_front());
        end
        if (w >= 0) ptr_m = (w + 1) % N;
        if (kill) begin
            init = 1'b1;
            istb = 1'b0;
            tick();
            chk("init_virq", {virq_a, virq_b}, 0);
            chk("init_iack", {iack_a, iack_b}, 0);
            chk("init_ivec", {ivec_a, ivec_b}, 0);
            chk("init_irq_ack", {irq_ack_a, irq_ack_b}, 0);
            init  = 1'b0;
            ptr_m = 0;
        end else begin
            istb = 1'b0;
            tick();
            chk("rel_iack_a", iack_a, 0);
            chk("rel_iack_b", iack_b, 0);
            chk("rel_ivec_a", ivec_a, 0);
            chk("rel_ivec_b", ivec_b, 0);
            chk("rel_virq_a", virq_a, 0);
        end
        tick();
        chk("virq_a_back", virq_a, |irq);
        chk("virq_b_back", virq_b, |irq);
    endtask

    // Aborted cycle: istb held for d edges (1 or 2) and dropped before either instance acks.
    task automatic run_abort(input int d);
        int w;
        logic [W-1:0] ev;
        w  = pick(irq, start_idx());
        ev = '0;
        if (w >= 0) ev = vec_m[w] & 16'hfffc;
        istb = 1'b1;
        tick();
        chk("ab_virq", {virq_a, virq_b}, 0);
        if (d == 2) begin
            tick();
            chk("ab_ivec_a", ivec_a, ev);
            chk("ab_ivec_b", ivec_b, ev);
            chk("ab_iack_a_t1", iack_a, 0);
        end
        istb = 1'b0;
        tick();
        chk("ab_iack", {iack_a, iack_b}, 0);
        chk("ab_irq_ack", {irq_ack_a, irq_ack_b}, 0);
        chk("ab_ivec", {ivec_a, ivec_b}, 0);
        tick();
        chk("ab_iack_late", {iack_a, iack_b, irq_ack_a, irq_ack_b}, 0);
        chk("ab_virq_a", virq_a, |irq);
        chk("ab_virq_b", virq_b, |irq);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        rst_n = 1'b0;
        init  = 1'b0;
        istb  = 1'b0;
        irq   = '1;
        for (int k = 0; k < N; k++) vec_m[k] = 16'($urandom);
        set_vecs();
        tick();
        tick();
        chk("rst_virq", {virq_a, virq_b}, 0);
        chk("rst_ivec", {ivec_a, ivec_b}, 0);
        chk("rst_iack", {iack_a, iack_b}, 0);
        chk("rst_irq_ack", {irq_ack_a, irq_ack_b}, 0);
        rst_n = 1'b1;

        // single request on source 1
        vec_m[1] = 16'o060;
        set_vecs();
        irq = 4'b0010;
        tick();
        chk("single_virq_a", virq_a, 1);
        chk("single_virq_b", virq_b, 1);
        tick();
        tick();
        run_ack(1'b0, 1'b1, 1'b1, 16'o060, 4'b0010);

        // priority between sources 1 and 3, starting from a cleared pointer
        init = 1'b1;
        tick();
        init  = 1'b0;
        ptr_m = 0;
        vec_m[1] = 16'o060;
        vec_m[3] = 16'o300;
        set_vecs();
        irq = 4'b1010;
        tick();
        run_ack(1'b0, 1'b1, 1'b1, 16'o060, 4'b0010);
`ifdef VIC_ROUND_ROBIN_EN
        run_ack(1'b0, 1'b1, 1'b1, 16'o300, 4'b1000);
`else
        run_ack(1'b0, 1'b1, 1'b1, 16'o060, 4'b0010);
`endif

        // passive release: request gone before istb
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        tick();
        run_ack(1'b0, 1'b1, 1'b1, 16'o000, 4'b0000);

        // aborted cycles
        irq = 4'b0100;
        vec_m[2] = 16'o1234;
        set_vecs();
        tick();
        run_abort(1);
        run_abort(2);

        // init during WAIT_REL, then a normal cycle
        irq = 4'b0001;
        tick();
        run_ack(1'b1, 1'b1, 1'b0, '0, '0);
        irq = 4'b0100;
        tick();
        run_ack(1'b0, 1'b0, 1'b0, '0, '0);

        // vector alignment on source 0
        vec_m[0] = 16'o063;
        set_vecs();
        irq = 4'b0001;
        tick();
        run_ack(1'b0, 1'b1, 1'b1, 16'o060, 4'b0001);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < N; k++) vec_m[k] = 16'($urandom);
            set_vecs();
            idle_cycles($urandom_range(1, 3));
            sel = $urandom_range(0, 9);
            if (sel < 7) run_ack(1'b0, 1'b0, 1'b0, '0, '0);
            else if (sel < 9) run_abort($urandom_range(1, 2));
            else run_ack(1'b1, 1'b0, 1'b0, '0, '0);
        end

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
